// File: rtl/fft_acc_ctrl_if.sv
// Processor-side port bundle of fft_acc_ctrl: sample write port, start/status
// and result read port. The controller uses the slave modport.
interface fft_acc_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0]   m_addr;
  logic [DATA_WIDTH-1:0]   m_data;
  logic                    m_we;
  logic                    start;
  logic                    busy;
  logic                    done;
  logic [1:0]              err;
  logic [ADDR_WIDTH-1:0]   s_addr;
  logic                    s_re;
  logic [2*DATA_WIDTH-1:0] s_data;
  logic                    s_valid;

  modport master (
    output m_addr, m_data, m_we, start, s_addr, s_re,
    input  busy, done, err, s_data, s_valid
  );

  modport slave (
    input  m_addr, m_data, m_we, start, s_addr, s_re,
    output busy, done, err, s_data, s_valid
  );
endinterface

// File: rtl/fft_acc_ctrl.sv
// Controller and buffer shell around a fixed-latency parallel FFT core:
// sample buffer, start/done handshake with timeout, and captured result buffer.
//
// state   | meaning
// IDLE    | accepting writes, waiting for start
// RUN     | core launched, waiting for core_done or timeout
// DONE    | results valid; behaves as IDLE for writes and start
module fft_acc_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int TIMEOUT    = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  fft_acc_ctrl_if.slave               bus,
  output logic [DEPTH*DATA_WIDTH-1:0] core_in,
  output logic                        core_start,
  input  logic [DEPTH*DATA_WIDTH-1:0] core_out_r,
  input  logic [DEPTH*DATA_WIDTH-1:0] core_out_i,
  input  logic                        core_done
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic                  done_q;
  logic [1:0]            err_q;
  logic [DATA_WIDTH-1:0] in_mem [DEPTH];
  logic [DATA_WIDTH-1:0] res_r  [DEPTH];
  logic [DATA_WIDTH-1:0] res_i  [DEPTH];

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;

  assign wr_in_range = ({1'b0, bus.m_addr} < DEPTH_L);
  assign rd_in_range = ({1'b0, bus.s_addr} < DEPTH_L);
  assign wr_idx      = bus.m_addr[IDX_W-1:0];
  assign rd_idx      = bus.s_addr[IDX_W-1:0];

  assign bus.busy = (state == ST_RUN);
  assign bus.done = done_q;
  assign bus.err  = err_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_flat
    assign core_in[k*DATA_WIDTH +: DATA_WIDTH] = in_mem[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      core_start <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 2'b00;
      for (int k = 0; k < DEPTH; k++) begin
        in_mem[k] <= '0;
        res_r[k]  <= '0;
        res_i[k]  <= '0;
      end
    end else begin
      core_start <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          // A write in the start cycle lands on the same edge, so the core sees it.
          if (bus.m_we && wr_in_range) in_mem[wr_idx] <= bus.m_data;
          if (bus.start) begin
            state      <= ST_RUN;
            cnt        <= '0;
            core_start <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 2'b00;
          end
        end
        ST_RUN: begin
          cnt <= cnt + 1'b1;
          if (bus.m_we || bus.start) err_q[0] <= 1'b1;
          // core_done on the last allowed cycle still counts as a completion.
          if (core_done) begin
            for (int k = 0; k < DEPTH; k++) begin
              res_r[k] <= core_out_r[k*DATA_WIDTH +: DATA_WIDTH];
              res_i[k] <= core_out_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
            state  <= ST_DONE;
            done_q <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            state    <= ST_IDLE;
            err_q[1] <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.s_valid <= 1'b0;
      bus.s_data  <= '0;
    end else if (bus.s_re) begin
      bus.s_valid <= 1'b1;
      bus.s_data  <= rd_in_range ? {res_r[rd_idx], res_i[rd_idx]} : '0;
    end else begin
      bus.s_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fft_acc_ctrl.sv
// Randomized bench for fft_acc_ctrl against an array-level reference model,
// with the FFT core played by the bench itself.
module tb_fft_acc_ctrl;
  localparam int DW    = 16;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int TO    = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DEPTH*DW-1:0] core_in;
  logic [DEPTH*DW-1:0] core_out_r = '0;
  logic [DEPTH*DW-1:0] core_out_i = '0;
  logic              core_start;
  logic              core_done = 1'b0;

  fft_acc_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fft_acc_ctrl #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .core_in    (core_in),
    .core_start (core_start),
    .core_out_r (core_out_r),
    .core_out_i (core_out_i),
    .core_done  (core_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] m_in [DEPTH];
  logic [DW-1:0] m_r  [DEPTH];
  logic [DW-1:0] m_i  [DEPTH];
  logic [DW-1:0] nx_r [DEPTH];
  logic [DW-1:0] nx_i [DEPTH];
  logic          m_done;
  logic [1:0]    m_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) begin
      m_in[k] = '0;
      m_r[k]  = '0;
      m_i[k]  = '0;
    end
    m_done = 1'b0;
    m_err  = 2'b00;
  endtask

  task automatic set_core(input bit rnd);
    logic [DW-1:0] kk;
    for (int k = 0; k < DEPTH; k++) begin
      kk = DW'(k);
      nx_r[k] = rnd ? DW'($urandom) : kk;
      nx_i[k] = rnd ? DW'($urandom) : ~kk;
      core_out_r[k*DW +: DW] = nx_r[k];
      core_out_i[k*DW +: DW] = nx_i[k];
    end
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.m_addr = a;
    bus.m_data = d;
    bus.m_we   = 1'b1;
    tick();
    bus.m_we   = 1'b0;
    if (int'(a) < DEPTH) m_in[a] = d;
  endtask

  task automatic check_core_in(input string tag);
    int nbad  = 0;
    int first = 0;
    for (int k = DEPTH - 1; k >= 0; k--)
      if (core_in[k*DW +: DW] !== m_in[k]) begin
        nbad++;
        first = k;
      end
    total++;
    if (nbad != 0) begin
      bad++;
      $display("FAIL %s core_in: %0d words differ, word %0d got %h want %h",
               tag, nbad, first, core_in[first*DW +: DW], m_in[first]);
    end
  endtask

  task automatic read_chk(input logic [AW-1:0] a, input string tag);
    logic [2*DW-1:0] exp;
    exp = (int'(a) < DEPTH) ? {m_r[a], m_i[a]} : '0;
    bus.s_addr = a;
    bus.s_re   = 1'b1;
    tick();
    bus.s_re   = 1'b0;
    total++;
    if (bus.s_valid !== 1'b1 || bus.s_data !== exp) begin
      bad++;
      $display("FAIL %s read addr=%0d: got valid=%b data=%h want valid=1 data=%h",
               tag, a, bus.s_valid, bus.s_data, exp);
    end
    bus.s_addr = AW'($urandom);
    tick();
    total++;
    if (bus.s_valid !== 1'b0 || bus.s_data !== exp) begin
      bad++;
      $display("FAIL %s read hold: got valid=%b data=%h want valid=0 data=%h",
               tag, bus.s_valid, bus.s_data, exp);
    end
  endtask

  task automatic check_status(input string tag);
    total++;
    if (bus.busy !== 1'b0 || bus.done !== m_done || bus.err !== m_err) begin
      bad++;
      $display("FAIL %s status: got busy=%b done=%b err=%b want busy=0 done=%b err=%b",
               tag, bus.busy, bus.done, bus.err, m_done, m_err);
    end
  endtask

  // delay = cycles after the core_start cycle at which core_done is asserted
  task automatic do_run(input int delay, input bit inject, input bit wr_with_start,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd, input string tag);
    int  busy_n;
    int  i;
    int  exp_busy;
    bit  capt;
    total++;
    if (core_start !== 1'b0) begin
      bad++;
      $display("FAIL %s core_start before launch: got %b want 0", tag, core_start);
    end
    bus.start = 1'b1;
    if (wr_with_start) begin
      bus.m_we   = 1'b1;
      bus.m_addr = wa;
      bus.m_data = wd;
      m_in[wa]   = wd;
    end
    tick();
    bus.start = 1'b0;
    bus.m_we  = 1'b0;
    m_err  = 2'b00;
    m_done = 1'b0;
    total++;
    if (core_start !== 1'b1 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL %s launch: got core_start=%b busy=%b want 1 1", tag, core_start, bus.busy);
    end
    check_core_in({tag, " at core_start"});
    busy_n = 0;
    i = 0;
    while (bus.busy === 1'b1 && i < TO + 8) begin
      busy_n++;
      core_done = (i == delay);
      if (inject && i == 1) begin
        bus.m_we   = 1'b1;
        bus.m_addr = '0;
        bus.m_data = 16'hBEEF;
        bus.start  = 1'b1;
        m_err[0]   = 1'b1;
      end
      tick();
      core_done = 1'b0;
      bus.m_we  = 1'b0;
      bus.start = 1'b0;
      if (i == 0) begin
        total++;
        if (core_start !== 1'b0) begin
          bad++;
          $display("FAIL %s core_start pulse width: got %b want 0 on second cycle", tag, core_start);
        end
      end
      i++;
    end
    capt = (delay <= TO - 1);
    exp_busy = capt ? delay + 1 : TO;
    if (capt) begin
      m_done = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
        m_r[k] = nx_r[k];
        m_i[k] = nx_i[k];
      end
    end else begin
      m_err[1] = 1'b1;
    end
    total++;
    if (busy_n != exp_busy) begin
      bad++;
      $display("FAIL %s busy_cycles: got %0d want %0d", tag, busy_n, exp_busy);
    end
    check_status(tag);
    check_core_in({tag, " after run"});
  endtask

  task automatic test_reset();
    model_reset();
    bus.m_addr = '0; bus.m_data = '0; bus.m_we = 1'b0; bus.start = 1'b0;
    bus.s_addr = '0; bus.s_re = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_status("reset");
    total++;
    if (core_start !== 1'b0 || bus.s_valid !== 1'b0 || bus.s_data !== '0) begin
      bad++;
      $display("FAIL reset outputs: got core_start=%b s_valid=%b s_data=%h want 0 0 0",
               core_start, bus.s_valid, bus.s_data);
    end
    check_core_in("reset");
    read_chk(5'd5, "reset");
  endtask

  task automatic test_nominal();
    for (int k = 0; k < DEPTH; k++) write_word(AW'(k), DW'(k + 1));
    set_core(1'b0);
    do_run(3, 1'b0, 1'b0, '0, '0, "nominal");
    total++;
    if (core_in[31*DW +: DW] !== 16'd32) begin
      bad++;
      $display("FAIL nominal word31: got %h want 0020", core_in[31*DW +: DW]);
    end
    read_chk(5'd3, "nominal");
    total++;
    if (bus.s_data !== 32'h0003_FFFC) begin
      bad++;
      $display("FAIL nominal addr3 value: got %h want 0003fffc", bus.s_data);
    end
    read_chk(5'd0, "nominal");
    read_chk(5'd31, "nominal");
  endtask

  task automatic test_busy_reject();
    set_core(1'b1);
    do_run(5, 1'b1, 1'b0, '0, '0, "busy_reject");
    read_chk(AW'($urandom), "busy_reject");
  endtask

  task automatic test_timeout();
    set_core(1'b1);
    do_run(1000, 1'b0, 1'b0, '0, '0, "timeout");
    read_chk(5'd3, "timeout");
    read_chk(AW'($urandom), "timeout");
  endtask

  task automatic test_boundary();
    set_core(1'b1);
    do_run(TO - 1, 1'b0, 1'b0, '0, '0, "last_cycle_done");
    read_chk(AW'($urandom), "last_cycle_done");
    set_core(1'b1);
    do_run(TO, 1'b0, 1'b0, '0, '0, "just_late");
    read_chk(AW'($urandom), "just_late");
  endtask

  task automatic test_same_cycle();
    set_core(1'b1);
    do_run(2, 1'b0, 1'b1, 5'd7, 16'h1234, "same_cycle");
    total++;
    if (core_in[7*DW +: DW] !== 16'h1234) begin
      bad++;
      $display("FAIL same_cycle word7: got %h want 1234", core_in[7*DW +: DW]);
    end
  endtask

  task automatic test_random();
    int n;
    int d;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(0, 8);
      for (int w = 0; w < n; w++) write_word(AW'($urandom), DW'($urandom));
      set_core(1'b1);
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      check_status("stray_done");
      set_core(1'b1);
      d = $urandom_range(0, TO + 2);
      do_run(d, (d >= 2) && ($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1,
             AW'($urandom), DW'($urandom), "random");
      for (int r = 0; r < 3; r++) read_chk(AW'($urandom), "random");
    end
  endtask

  task automatic test_reset_midrun();
    set_core(1'b1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL midrun busy before reset: got %b want 1", bus.busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check_status("midrun_reset");
    total++;
    if (core_start !== 1'b0 || bus.s_valid !== 1'b0 || bus.s_data !== '0) begin
      bad++;
      $display("FAIL midrun_reset outputs: got core_start=%b s_valid=%b s_data=%h want 0 0 0",
               core_start, bus.s_valid, bus.s_data);
    end
    check_core_in("midrun_reset");
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check_status("late_done");
    read_chk(AW'($urandom), "late_done");
    read_chk(5'd3, "late_done");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_busy_reject();
    test_timeout();
    test_boundary();
    test_same_cycle();
    test_random();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
